// File: rtl/enemy_anim_sequencer.sv
// Per-enemy animation sequencer: stand/walk/one-shot attack FSM driving registered sprite-sheet coordinates.
// Optional hit-stun behaviour (HURT state, blinking) is compiled in with `define HIT_STUN_EN.
module enemy_anim_sequencer #(
    parameter int FRAMES          = 4,
    parameter int TICKS_PER_FRAME = 8,
    parameter int TILE            = 8,
    parameter int ATK_W           = 8,
    parameter int ATK_OFFSET      = 4,
    parameter int WALK_COL0       = 4,
    parameter int ROW_R           = 5,
    parameter int ROW_L           = 6,
    parameter int ATK_ROW_R       = 72,
    parameter int ATK_ROW_L       = 84,
    parameter int STUN_TICKS      = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [1:0] behavior_req,
    input  logic       isLeft,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       hit,
    output logic [7:0] NewDrawX,
    output logic [7:0] NewDrawY,
    output logic [6:0] SpriteX,
    output logic [6:0] SpriteY,
    output logic       is_8,
    output logic [2:0] period,
    output logic       attack_done,
    output logic       visible
);

    localparam int TW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam logic [TW-1:0] TICK_LAST   = TW'(TICKS_PER_FRAME - 1);
    localparam logic [2:0]    PERIOD_LAST = 3'(FRAMES - 1);

    localparam logic [6:0] STAND_X     = 7'(TILE * WALK_COL0);
    localparam logic [6:0] TILE_Y_R    = 7'(TILE * ROW_R);
    localparam logic [6:0] TILE_Y_L    = 7'(TILE * ROW_L);
    localparam logic [6:0] ATK_Y_R     = 7'(ATK_ROW_R);
    localparam logic [6:0] ATK_Y_L     = 7'(ATK_ROW_L);
    localparam logic [7:0] ATK_SHIFT_X = 8'(ATK_OFFSET);

    // Any parameter set that would push a sprite coordinate past the 7-bit sheet is rejected here.
    if (FRAMES < 2 || FRAMES > 8) begin : g_bad_frames
        $error("enemy_anim_sequencer: FRAMES must be 2..8");
    end
    if (TICKS_PER_FRAME < 1) begin : g_bad_ticks
        $error("enemy_anim_sequencer: TICKS_PER_FRAME must be >= 1");
    end
    if (STUN_TICKS < 1) begin : g_bad_stun
        $error("enemy_anim_sequencer: STUN_TICKS must be >= 1");
    end
    if (TILE * (WALK_COL0 + FRAMES - 1) > 127) begin : g_bad_walk_x
        $error("enemy_anim_sequencer: walk sprite X exceeds 127");
    end
    if (TILE * ROW_R > 127 || TILE * ROW_L > 127) begin : g_bad_tile_y
        $error("enemy_anim_sequencer: tile sprite Y exceeds 127");
    end
    if (ATK_W * (FRAMES - 1) > 127) begin : g_bad_atk_x
        $error("enemy_anim_sequencer: attack sprite X exceeds 127");
    end
    if (ATK_ROW_R > 127 || ATK_ROW_L > 127) begin : g_bad_atk_y
        $error("enemy_anim_sequencer: attack sprite Y exceeds 127");
    end

`ifdef HIT_STUN_EN
    typedef enum logic [1:0] {ST_STAND, ST_WALK, ST_ATTACK, ST_HURT} state_t;
    localparam int SW = $clog2(STUN_TICKS + 1);
    logic [SW-1:0] stun, stun_n;
`else
    typedef enum logic [1:0] {ST_STAND, ST_WALK, ST_ATTACK} state_t;
    logic unused_hit;
    assign unused_hit = hit;
`endif

    state_t        state, state_n, req_state;
    logic [2:0]    period_q, period_n;
    logic [TW-1:0] tick, tick_n;
    logic          dir_latch, dir_n;
    logic          done_n;
    logic          vis, vis_n;
    logic          wrap;

    logic [7:0]    draw_x_n;
    logic [6:0]    sprite_x_n, sprite_y_n;
    logic          is8_n;
    logic          d_n;

    always_comb begin
        case (behavior_req)
            2'd1:    req_state = ST_WALK;
            2'd2:    req_state = ST_ATTACK;
            default: req_state = ST_STAND;
        endcase
    end

    assign wrap = frame_tick && (tick == TICK_LAST);

    always_comb begin
        state_n  = state;
        period_n = period_q;
        tick_n   = tick;
        dir_n    = dir_latch;
        done_n   = 1'b0;
        vis_n    = vis;
`ifdef HIT_STUN_EN
        stun_n   = stun;
`endif
        case (state)
            ST_STAND, ST_WALK: begin
                if (req_state != state) begin
                    state_n  = req_state;
                    period_n = 3'd0;
                    tick_n   = '0;
                    if (req_state == ST_ATTACK) dir_n = isLeft;
                end else if (wrap) begin
                    tick_n = '0;
                    if (state == ST_WALK)
                        period_n = (period_q == PERIOD_LAST) ? 3'd0 : period_q + 3'd1;
                    else
                        period_n = 3'd0;
                end else if (frame_tick) begin
                    tick_n = tick + TW'(1);
                end
            end
            // The attack ignores behavior_req until its last frame wraps.
            ST_ATTACK: begin
                if (wrap) begin
                    tick_n = '0;
                    if (period_q == PERIOD_LAST) begin
                        done_n   = 1'b1;
                        period_n = 3'd0;
                        state_n  = req_state;
                        if (req_state == ST_ATTACK) dir_n = isLeft;
                    end else begin
                        period_n = period_q + 3'd1;
                    end
                end else if (frame_tick) begin
                    tick_n = tick + TW'(1);
                end
            end
`ifdef HIT_STUN_EN
            ST_HURT: begin
                if (frame_tick) begin
                    if (stun <= SW'(1)) begin
                        stun_n   = '0;
                        vis_n    = 1'b1;
                        state_n  = req_state;
                        period_n = 3'd0;
                        tick_n   = '0;
                        if (req_state == ST_ATTACK) dir_n = isLeft;
                    end else begin
                        stun_n = stun - SW'(1);
                        vis_n  = ~vis;
                    end
                end
            end
`endif
            default: begin
                state_n  = ST_STAND;
                period_n = 3'd0;
                tick_n   = '0;
            end
        endcase
`ifdef HIT_STUN_EN
        // A hit pre-empts everything, including a running attack, and restarts the stun window.
        if (hit) begin
            state_n  = ST_HURT;
            period_n = 3'd0;
            tick_n   = '0;
            stun_n   = SW'(STUN_TICKS);
            done_n   = 1'b0;
        end
`endif
    end

    // Outputs are built from the next-state values so a sampled input shows up after one Clk.
    always_comb begin
        d_n        = (state_n == ST_ATTACK) ? dir_n : isLeft;
        sprite_x_n = STAND_X;
        sprite_y_n = d_n ? TILE_Y_L : TILE_Y_R;
        is8_n      = 1'b1;
        draw_x_n   = x;
        case (state_n)
            ST_WALK: begin
                sprite_x_n = 7'(TILE * (WALK_COL0 + int'(period_n)));
            end
            ST_ATTACK: begin
                sprite_x_n = 7'(ATK_W * int'(period_n));
                sprite_y_n = d_n ? ATK_Y_L : ATK_Y_R;
                is8_n      = 1'b0;
                if (d_n) draw_x_n = x - ATK_SHIFT_X;
            end
            default: begin
                sprite_x_n = STAND_X;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_STAND;
            period_q    <= 3'd0;
            tick        <= '0;
            dir_latch   <= 1'b0;
            vis         <= 1'b1;
            attack_done <= 1'b0;
            NewDrawX    <= 8'd0;
            NewDrawY    <= 8'd0;
            SpriteX     <= STAND_X;
            SpriteY     <= TILE_Y_R;
            is_8        <= 1'b1;
        end else begin
            state       <= state_n;
            period_q    <= period_n;
            tick        <= tick_n;
            dir_latch   <= dir_n;
            vis         <= vis_n;
            attack_done <= done_n;
            NewDrawX    <= draw_x_n;
            NewDrawY    <= y;
            SpriteX     <= sprite_x_n;
            SpriteY     <= sprite_y_n;
            is_8        <= is8_n;
        end
    end

`ifdef HIT_STUN_EN
    always_ff @(posedge Clk) begin
        if (Reset) stun <= '0;
        else       stun <= stun_n;
    end
`endif

    assign period  = period_q;
    assign visible = vis;

endmodule

// File: tb/tb_enemy_anim_sequencer.sv
// Directed self-checking bench for enemy_anim_sequencer at default parameters.
module tb_enemy_anim_sequencer;

    logic       Clk = 1'b0;
    logic       Reset, frame_tick, isLeft, hit;
    logic [1:0] behavior_req;
    logic [7:0] x, y;
    logic [7:0] NewDrawX, NewDrawY;
    logic [6:0] SpriteX, SpriteY;
    logic       is_8, attack_done, visible;
    logic [2:0] period;

    int errors = 0;
    int checks = 0;

    enemy_anim_sequencer dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .behavior_req(behavior_req),
        .isLeft(isLeft), .x(x), .y(y), .hit(hit),
        .NewDrawX(NewDrawX), .NewDrawY(NewDrawY), .SpriteX(SpriteX), .SpriteY(SpriteY),
        .is_8(is_8), .period(period), .attack_done(attack_done), .visible(visible)
    );

    always #5 Clk = ~Clk;

    // Inputs change 1ns after a rising edge and outputs are sampled there too.
    task automatic applyStimulus();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; behavior_req = 2'd2; x = 8'd50; y = 8'd7;
        isLeft = 1'b0; frame_tick = 1'b0; hit = 1'b0;
        applyStimulus();
        applyStimulus();
        checks++;
        if ({SpriteX, SpriteY, is_8} !== {7'd32, 7'd40, 1'b1}) begin
            errors++; $display("[TB] FAIL reset_sprite: got X=%0d Y=%0d is_8=%0b want 32 40 1", SpriteX, SpriteY, is_8);
        end
        checks++;
        if ({NewDrawX, NewDrawY} !== {8'd0, 8'd0}) begin
            errors++; $display("[TB] FAIL reset_draw: got %0d,%0d want 0,0", NewDrawX, NewDrawY);
        end
        checks++;
        if ({period, attack_done, visible} !== {3'd0, 1'b0, 1'b1}) begin
            errors++; $display("[TB] FAIL reset_ctrl: got period=%0d done=%0b vis=%0b want 0 0 1", period, attack_done, visible);
        end
        Reset = 1'b0; behavior_req = 2'd0; isLeft = 1'b1;
        applyStimulus();
        checks++;
        if ({SpriteX, SpriteY, NewDrawX, NewDrawY} !== {7'd32, 7'd48, 8'd50, 8'd7}) begin
            errors++; $display("[TB] FAIL stand_left: got X=%0d Y=%0d dx=%0d dy=%0d want 32 48 50 7", SpriteX, SpriteY, NewDrawX, NewDrawY);
        end
    endtask

    task automatic test_walk();
        int exp_p;
        behavior_req = 2'd1; isLeft = 1'b0;
        applyStimulus();
        checks++;
        if ({period, SpriteX, SpriteY, is_8} !== {3'd0, 7'd32, 7'd40, 1'b1}) begin
            errors++; $display("[TB] FAIL walk_entry: got p=%0d X=%0d Y=%0d is_8=%0b want 0 32 40 1", period, SpriteX, SpriteY, is_8);
        end
        frame_tick = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            applyStimulus();
            if (i % 8 == 0 || i % 8 == 7) begin
                exp_p = (i / 8) % 4;
                checks++;
                if ({period, SpriteX} !== {3'(exp_p), 7'(32 + 8 * exp_p)}) begin
                    errors++; $display("[TB] FAIL walk_tick%0d: got p=%0d X=%0d want p=%0d X=%0d", i, period, SpriteX, exp_p, 32 + 8 * exp_p);
                end
            end
        end
        frame_tick = 1'b0;
    endtask

    task automatic test_attack();
        int done_cnt = 0;
        behavior_req = 2'd2; isLeft = 1'b1; x = 8'd2;
        applyStimulus();
        checks++;
        if ({NewDrawX, SpriteX, SpriteY, is_8, period} !== {8'd254, 7'd0, 7'd84, 1'b0, 3'd0}) begin
            errors++; $display("[TB] FAIL attack_entry: got dx=%0d X=%0d Y=%0d is_8=%0b p=%0d want 254 0 84 0 0", NewDrawX, SpriteX, SpriteY, is_8, period);
        end
        behavior_req = 2'd0; frame_tick = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            isLeft = 1'(i % 2);
            applyStimulus();
            if (attack_done) done_cnt++;
            if (i < 32) begin
                if (i % 8 == 0) begin
                    checks++;
                    if (SpriteX !== 7'(8 * (i / 8))) begin
                        errors++; $display("[TB] FAIL attack_frame%0d: got X=%0d want %0d", i, SpriteX, 8 * (i / 8));
                    end
                end
                checks++;
                if ({SpriteY, NewDrawX, is_8} !== {7'd84, 8'd254, 1'b0}) begin
                    errors++; $display("[TB] FAIL attack_dir_hold%0d: got Y=%0d dx=%0d is_8=%0b want 84 254 0", i, SpriteY, NewDrawX, is_8);
                end
            end else begin
                checks++;
                if ({attack_done, SpriteX, SpriteY, is_8, NewDrawX} !== {1'b1, 7'd32, 7'd40, 1'b1, 8'd2}) begin
                    errors++; $display("[TB] FAIL attack_end: got done=%0b X=%0d Y=%0d is_8=%0b dx=%0d want 1 32 40 1 2", attack_done, SpriteX, SpriteY, is_8, NewDrawX);
                end
            end
        end
        frame_tick = 1'b0;
        applyStimulus();
        if (attack_done) done_cnt++;
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("[TB] FAIL attack_done_count: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int early_done = 0;
        behavior_req = 2'd2; isLeft = 1'b0; x = 8'd100;
        applyStimulus();
        checks++;
        if ({SpriteY, NewDrawX, is_8} !== {7'd72, 8'd100, 1'b0}) begin
            errors++; $display("[TB] FAIL b2b_entry: got Y=%0d dx=%0d is_8=%0b want 72 100 0", SpriteY, NewDrawX, is_8);
        end
        frame_tick = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            if (i == 32) isLeft = 1'b1;
            applyStimulus();
            if (i < 32 && attack_done) early_done++;
        end
        checks++;
        if ({attack_done, period, SpriteX, SpriteY, is_8, NewDrawX} !== {1'b1, 3'd0, 7'd0, 7'd84, 1'b0, 8'd96}) begin
            errors++; $display("[TB] FAIL b2b_restart: got done=%0b p=%0d X=%0d Y=%0d is_8=%0b dx=%0d want 1 0 0 84 0 96",
                               attack_done, period, SpriteX, SpriteY, is_8, NewDrawX);
        end
        checks++;
        if (early_done !== 0) begin
            errors++; $display("[TB] FAIL b2b_early_done: got %0d pulses want 0", early_done);
        end
        frame_tick = 1'b0;
        applyStimulus();
        checks++;
        if ({attack_done, is_8, SpriteY, period} !== {1'b0, 1'b0, 7'd84, 3'd0}) begin
            errors++; $display("[TB] FAIL b2b_no_gap: got done=%0b is_8=%0b Y=%0d p=%0d want 0 0 84 0", attack_done, is_8, SpriteY, period);
        end
    endtask

    task automatic test_reset_mid_attack();
        int done_cnt = 0;
        frame_tick = 1'b1;
        repeat (16) applyStimulus();
        checks++;
        if ({period, SpriteX} !== {3'd2, 7'd16}) begin
            errors++; $display("[TB] FAIL mid_attack_pos: got p=%0d X=%0d want 2 16", period, SpriteX);
        end
        frame_tick = 1'b0; behavior_req = 2'd0; Reset = 1'b1;
        applyStimulus();
        checks++;
        if ({SpriteX, SpriteY, is_8, period, attack_done, NewDrawX} !== {7'd32, 7'd40, 1'b1, 3'd0, 1'b0, 8'd0}) begin
            errors++; $display("[TB] FAIL mid_attack_reset: got X=%0d Y=%0d is_8=%0b p=%0d done=%0b dx=%0d want 32 40 1 0 0 0",
                               SpriteX, SpriteY, is_8, period, attack_done, NewDrawX);
        end
        Reset = 1'b0; isLeft = 1'b0; frame_tick = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            if (attack_done) done_cnt++;
        end
        frame_tick = 1'b0;
        checks++;
        if ({done_cnt[3:0], is_8, period} !== {4'd0, 1'b1, 3'd0}) begin
            errors++; $display("[TB] FAIL post_reset_stand: got done_cnt=%0d is_8=%0b p=%0d want 0 1 0", done_cnt, is_8, period);
        end
    endtask

    task automatic test_walk_to_stand_wrap();
        behavior_req = 2'd1; isLeft = 1'b0;
        applyStimulus();
        frame_tick = 1'b1;
        repeat (15) applyStimulus();
        frame_tick = 1'b0; isLeft = 1'b1;
        applyStimulus();
        checks++;
        if ({period, SpriteX, SpriteY} !== {3'd1, 7'd40, 7'd48}) begin
            errors++; $display("[TB] FAIL walk_turn: got p=%0d X=%0d Y=%0d want 1 40 48", period, SpriteX, SpriteY);
        end
        behavior_req = 2'd0; frame_tick = 1'b1;
        applyStimulus();
        checks++;
        if ({period, SpriteX, is_8} !== {3'd0, 7'd32, 1'b1}) begin
            errors++; $display("[TB] FAIL change_beats_tick: got p=%0d X=%0d is_8=%0b want 0 32 1", period, SpriteX, is_8);
        end
        behavior_req = 2'd1; frame_tick = 1'b0;
        applyStimulus();
        frame_tick = 1'b1;
        repeat (7) applyStimulus();
        checks++;
        if (period !== 3'd0) begin
            errors++; $display("[TB] FAIL tick_cleared: got p=%0d want 0", period);
        end
        applyStimulus();
        frame_tick = 1'b0;
        checks++;
        if ({period, SpriteX} !== {3'd1, 7'd40}) begin
            errors++; $display("[TB] FAIL tick_cleared_wrap: got p=%0d X=%0d want 1 40", period, SpriteX);
        end
    endtask

`ifdef HIT_STUN_EN
    task automatic test_hit();
        int toggles = 0;
        int done_cnt = 0;
        logic prev_vis;
        behavior_req = 2'd2; isLeft = 1'b0;
        applyStimulus();
        frame_tick = 1'b1;
        repeat (16) applyStimulus();
        frame_tick = 1'b0; hit = 1'b1;
        applyStimulus();
        hit = 1'b0;
        checks++;
        if ({is_8, SpriteX, SpriteY, period, visible, attack_done} !== {1'b1, 7'd32, 7'd40, 3'd0, 1'b1, 1'b0}) begin
            errors++; $display("[TB] FAIL hurt_entry: got is_8=%0b X=%0d Y=%0d p=%0d vis=%0b done=%0b want 1 32 40 0 1 0",
                               is_8, SpriteX, SpriteY, period, visible, attack_done);
        end
        prev_vis = visible;
        frame_tick = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            applyStimulus();
            if (visible !== prev_vis) toggles++;
            prev_vis = visible;
            if (attack_done) done_cnt++;
            if (i < 16) begin
                checks++;
                if (is_8 !== 1'b1) begin
                    errors++; $display("[TB] FAIL hurt_stand%0d: got is_8=%0b want 1", i, is_8);
                end
            end else begin
                checks++;
                if ({is_8, visible, period} !== {1'b0, 1'b1, 3'd0}) begin
                    errors++; $display("[TB] FAIL hurt_exit: got is_8=%0b vis=%0b p=%0d want 0 1 0", is_8, visible, period);
                end
            end
        end
        frame_tick = 1'b0;
        checks++;
        if ({toggles[4:0], done_cnt[3:0]} !== {5'd16, 4'd0}) begin
            errors++; $display("[TB] FAIL hurt_blink: got toggles=%0d done=%0d want 16 0", toggles, done_cnt);
        end
    endtask
`else
    task automatic test_hit();
        hit = 1'b1;
        applyStimulus();
        hit = 1'b0;
        checks++;
        if ({period, visible, is_8, SpriteX} !== {3'd1, 1'b1, 1'b1, 7'd40}) begin
            errors++; $display("[TB] FAIL hit_ignored: got p=%0d vis=%0b is_8=%0b X=%0d want 1 1 1 40", period, visible, is_8, SpriteX);
        end
        frame_tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checks++;
            if (visible !== 1'b1) begin
                errors++; $display("[TB] FAIL visible_const%0d: got %0b want 1", i, visible);
            end
        end
        frame_tick = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_walk();
        test_attack();
        test_back_to_back();
        test_reset_mid_attack();
        test_walk_to_stand_wrap();
        test_hit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
